goertzel_ctrl: RTL and testbench

//  Sequencer for the Goertzel filter bank. On start, obtains the NF per-bin

---
 rtl/goertzel_ctrl.sv | 115 +++++++++++
 tb/tb_goertzel_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/goertzel_ctrl.sv
// Goertzel filter-bank sequencer: fetches Cordic coefficients once per reset, then runs
// each block of NS samples through the shared bin datapath and a final-output pass.
module goertzel_ctrl #(
  parameter int unsigned NF = 11,
  parameter int unsigned NS = 256,
  parameter int unsigned DW = 16,
  localparam int unsigned BW = (NF > 1) ? $clog2(NF) : 1,
  localparam int unsigned CW = (NS > 1) ? $clog2(NS) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          cordic_en,
  input  logic          cordic_vld,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic [DW-1:0] smp_o,
  output logic [BW-1:0] bin_idx,
  output logic          step_en,
  output logic          first_o,
  output logic          fin_en
);

  typedef enum logic [2:0] {StIdle, StCoef, StSamp, StIter, StFin, StDone} state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic            r_coef_ok;
  logic [BW-1:0]   r_bin;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_smp;
  logic            w_bin_last;
  logic            w_cnt_last;

  assign w_bin_last = (r_bin == BW'(NF - 1));
  assign w_cnt_last = (r_cnt == CW'(NS - 1));
  assign bin_idx    = r_bin;
  assign smp_o      = r_smp;

  // Outputs decode from state only, so an async reset clears them immediately.
  always_comb begin
    w_state_d = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    cordic_en = 1'b0;
    s_ready   = 1'b0;
    step_en   = 1'b0;
    first_o   = 1'b0;
    fin_en    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) w_state_d = r_coef_ok ? StSamp : StCoef;
      end
      StCoef: begin
        busy      = 1'b1;
        cordic_en = 1'b1;
        if (cordic_vld) w_state_d = StSamp;
      end
      StSamp: begin
        busy    = 1'b1;
        s_ready = 1'b1;
        if (s_valid) w_state_d = StIter;
      end
      StIter: begin
        busy    = 1'b1;
        step_en = 1'b1;
        first_o = (r_cnt == '0);
        if (w_bin_last) w_state_d = w_cnt_last ? StFin : StSamp;
      end
      StFin: begin
        busy   = 1'b1;
        fin_en = 1'b1;
        if (w_bin_last) w_state_d = StDone;
      end
      StDone: begin
        done      = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= StIdle;
      r_coef_ok <= 1'b0;
      r_bin     <= '0;
      r_cnt     <= '0;
      r_smp     <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StCoef && cordic_vld) r_coef_ok <= 1'b1;
      case (r_state)
        StSamp: begin
          if (s_valid) begin
            r_smp <= s_data;
            r_bin <= '0;
          end
        end
        StIter: begin
          r_bin <= w_bin_last ? '0 : r_bin + 1'b1;
          // Counter parks at NS-1 through FIN and is cleared in DONE.
          if (w_bin_last && !w_cnt_last) r_cnt <= r_cnt + 1'b1;
        end
        StFin:   r_bin <= w_bin_last ? '0 : r_bin + 1'b1;
        StDone:  r_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_goertzel_ctrl.sv
// Directed bench for goertzel_ctrl with NF=11, NS=4: coefficient fetch, block timing,
// stalls, ignored start, mid-block reset.
module tb_goertzel_ctrl;
  localparam int unsigned NF = 11;
  localparam int unsigned NS = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 4;

  logic          clk;
  logic          rstn;
  logic          start;
  logic          busy;
  logic          done;
  logic          cordic_en;
  logic          cordic_vld;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic [DW-1:0] smp_o;
  logic [BW-1:0] bin_idx;
  logic          step_en;
  logic          first_o;
  logic          fin_en;

  int n_tests = 0;
  int n_fail  = 0;

  goertzel_ctrl #(.NF(NF), .NS(NS), .DW(DW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .cordic_en (cordic_en),
    .cordic_vld(cordic_vld),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .smp_o     (smp_o),
    .bin_idx   (bin_idx),
    .step_en   (step_en),
    .first_o   (first_o),
    .fin_en    (fin_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"},      32'(busy),      32'd0);
    chk({tag, ".done"},      32'(done),      32'd0);
    chk({tag, ".cordic_en"}, 32'(cordic_en), 32'd0);
    chk({tag, ".s_ready"},   32'(s_ready),   32'd0);
    chk({tag, ".smp_o"},     32'(smp_o),     32'd0);
    chk({tag, ".bin_idx"},   32'(bin_idx),   32'd0);
    chk({tag, ".step_en"},   32'(step_en),   32'd0);
    chk({tag, ".first_o"},   32'(first_o),   32'd0);
    chk({tag, ".fin_en"},    32'(fin_en),    32'd0);
  endtask

  // Entered in the first SAMP cycle; drives NS samples and checks every cycle to done.
  task automatic run_block(input logic [63:0] words, input int gap_at, input int gap_len,
                           input bit inject_start);
    logic [15:0] d;
    logic [15:0] prev;
    prev = smp_o;
    for (int s = 0; s < int'(NS); s++) begin
      d = words[16*s +: 16];
      if (s == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          s_valid = 1'b0;
          chk("gap.s_ready", 32'(s_ready), 32'd1);
          chk("gap.step_en", 32'(step_en), 32'd0);
          chk("gap.smp_o",   32'(smp_o),   32'(prev));
          tick();
        end
      end
      s_valid = 1'b1;
      s_data  = d;
      chk("samp.s_ready", 32'(s_ready), 32'd1);
      chk("samp.busy",    32'(busy),    32'd1);
      tick();
      s_data = 16'hDEAD;  // must not be captured outside SAMP
      for (int b = 0; b < int'(NF); b++) begin
        chk("iter.step_en", 32'(step_en), 32'd1);
        chk("iter.bin_idx", 32'(bin_idx), 32'(b));
        chk("iter.first_o", 32'(first_o), 32'(s == 0));
        chk("iter.smp_o",   32'(smp_o),   32'(d));
        chk("iter.s_ready", 32'(s_ready), 32'd0);
        chk("iter.fin_en",  32'(fin_en),  32'd0);
        if (inject_start && s == 1 && b == 3) start = 1'b1;
        tick();
        start = 1'b0;
      end
      prev = d;
    end
    s_valid = 1'b0;
    for (int b = 0; b < int'(NF); b++) begin
      chk("fin.fin_en",  32'(fin_en),  32'd1);
      chk("fin.bin_idx", 32'(bin_idx), 32'(b));
      chk("fin.step_en", 32'(step_en), 32'd0);
      chk("fin.busy",    32'(busy),    32'd1);
      tick();
    end
    chk("done.pulse", 32'(done), 32'd1);
    chk("done.busy",  32'(busy), 32'd0);
    tick();
    chk("idle.done",    32'(done),    32'd0);
    chk("idle.busy",    32'(busy),    32'd0);
    chk("idle.s_ready", 32'(s_ready), 32'd0);
    tick();
    chk("idle2.done", 32'(done), 32'd0);
  endtask

  initial begin
    int edges;
    int n_busy;
    int n_step;
    int n_fin;
    int n_first;
    bit found;

    rstn       = 1'b0;
    start      = 1'b0;
    cordic_vld = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    #12;
    chk_all_zero("reset");
    tick();
    rstn = 1'b1;
    tick();
    chk_all_zero("idle_after_reset");

    // Coefficient fetch: vld arrives after 5 enable cycles.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("coef.cordic_en", 32'(cordic_en), 32'd1);
      chk("coef.s_ready",   32'(s_ready),   32'd0);
      chk("coef.busy",      32'(busy),      32'd1);
      tick();
    end
    cordic_vld = 1'b1;
    chk("coef_vld.cordic_en", 32'(cordic_en), 32'd1);
    tick();
    chk("coef_exit.s_ready",   32'(s_ready),   32'd1);
    chk("coef_exit.cordic_en", 32'(cordic_en), 32'd0);
    run_block(64'hFFFF_0001_8000_7FFF, -1, 0, 1'b0);

    // Free-running block with coefficients already valid.
    s_valid = 1'b1;
    s_data  = 16'h1234;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    edges   = 1;
    n_busy  = 0;
    n_step  = 0;
    n_fin   = 0;
    n_first = 0;
    while (done !== 1'b1 && edges < 200) begin
      if (cordic_en === 1'b1) n_busy += 1000;
      if (busy === 1'b1) n_busy++;
      if (step_en === 1'b1) n_step++;
      if (fin_en === 1'b1) n_fin++;
      if (first_o === 1'b1 && step_en === 1'b1) n_first++;
      tick();
      edges++;
    end
    chk("run.done_seen",  32'(done),    32'd1);
    chk("run.edges",      32'(edges),   32'd60);
    chk("run.busy_cyc",   32'(n_busy),  32'd59);
    chk("run.step_count", 32'(n_step),  32'd44);
    chk("run.fin_count",  32'(n_fin),   32'd11);
    chk("run.first_cnt",  32'(n_first), 32'd11);
    s_valid = 1'b0;
    tick();
    chk("run.done_1cyc", 32'(done), 32'd0);

    // Stall of 3 cycles before sample 2, plus a start pulse during ITER.
    start = 1'b1;
    tick();
    start = 1'b0;
    run_block(64'h0F0F_5555_AAAA_0002, 2, 3, 1'b1);

    // Reset during FIN at bin 5 aborts, then start refetches coefficients.
    s_valid = 1'b1;
    s_data  = 16'h4321;
    start   = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (fin_en === 1'b1 && bin_idx === 4'd5) found = 1'b1;
      else tick();
    end
    chk("abort.reached_fin5", 32'(found), 32'd1);
    rstn = 1'b0;
    #1;
    chk_all_zero("abort");
    #1;
    rstn    = 1'b1;
    s_valid = 1'b0;
    tick();
    chk_all_zero("abort_idle");
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("recoef.cordic_en", 32'(cordic_en), 32'd1);
    chk("recoef.s_ready",   32'(s_ready),   32'd0);
    tick();
    chk("recoef_1cyc.cordic_en", 32'(cordic_en), 32'd0);
    chk("recoef_1cyc.s_ready",   32'(s_ready),   32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
